// File: rtl/csa_pipe_adder_pkg.sv
// Shared constants and types for the pipelined carry-select adder.
// Default geometry, per-stage control struct and the overflow rule.
package csa_pkg;
   localparam int CSA_WIDTH  = 128;
   localparam int CSA_BLOCK  = 8;
   localparam int CSA_STAGES = 4;

   // Width-independent part of a stage register. The width-dependent parts
   // (resolved sum bits, pending operand bits) sit beside it in the top.
   typedef struct packed {
      logic vld;
      logic carry;
      logic a_msb;
      logic b_msb;
   } csa_ctl_t;

   function automatic logic ovf_of(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction
endpackage

// File: rtl/csa_pipe_adder_if.sv
// Operand/result handshake bundle for csa_pipe_adder.
// The slave modport is the adder side.
interface csa_pipe_adder_if
   import csa_pkg::*;
#(parameter int WIDTH = CSA_WIDTH);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;

   modport slave (
      input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf
   );
   modport master (
      output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf
   );
endinterface

// File: rtl/csa_pipe_adder_block.sv
// Combinational BLOCK-bit carry-select cell: two ripple paths (cin=0/1)
// computed in parallel, the real carry-in picks one.
module csa_block #(
   parameter int BLOCK = 8
) (
   input  logic [BLOCK-1:0] i_a,
   input  logic [BLOCK-1:0] i_b,
   input  logic             i_cin,
   output logic [BLOCK-1:0] o_sum,
   output logic             o_cout
);
   logic [BLOCK-1:0] w_s0, w_s1;
   logic             w_c0, w_c1;

   always_comb begin
      logic c0, c1;
      c0   = 1'b0;
      c1   = 1'b1;
      w_s0 = '0;
      w_s1 = '0;
      for (int i = 0; i < BLOCK; i++) begin
         w_s0[i] = i_a[i] ^ i_b[i] ^ c0;
         w_s1[i] = i_a[i] ^ i_b[i] ^ c1;
         c0 = (i_a[i] & i_b[i]) | (c0 & (i_a[i] ^ i_b[i]));
         c1 = (i_a[i] & i_b[i]) | (c1 & (i_a[i] ^ i_b[i]));
      end
      w_c0 = c0;
      w_c1 = c1;
   end

   assign o_sum  = i_cin ? w_s1 : w_s0;
   assign o_cout = i_cin ? w_c1 : w_c0;
endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor: stage k resolves one WIDTH/STAGES
// slice, carries and not-yet-added operand bits ride the stage registers.
module csa_pipe_adder
   import csa_pkg::*;
#(
   parameter int WIDTH  = CSA_WIDTH,
   parameter int BLOCK  = CSA_BLOCK,
   parameter int STAGES = CSA_STAGES
) (
   input logic             clk,
   input logic             rst_n,
   csa_pipe_adder_if.slave bus
);
   localparam int SW = WIDTH / STAGES;
   localparam int NB = SW / BLOCK;

   if (WIDTH % BLOCK != 0) begin : g_chk_block
      $error("csa_pipe_adder: WIDTH must be a multiple of BLOCK");
   end
   if ((WIDTH / BLOCK) % STAGES != 0) begin : g_chk_stages
      $error("csa_pipe_adder: WIDTH/BLOCK must be a multiple of STAGES");
   end

   logic             w_adv;
   csa_ctl_t         w_last_ctl;
   logic [WIDTH-1:0] w_last_sum;

   // Global stall: every stage moves only when the output slot frees up.
   assign w_adv        = !w_last_ctl.vld || bus.out_ready;
   assign bus.in_ready = w_adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int IW = WIDTH - k*SW;  // operand bits still pending at this stage
      csa_ctl_t         w_ctl_i, w_ctl_n, r_ctl;
      logic [IW-1:0]    w_a_i, w_b_i;
      logic [WIDTH-1:0] w_sum_i, w_sum_n, r_sum;
      logic [SW-1:0]    w_s;

      if (k == 0) begin : g_src
         assign w_a_i   = bus.in_a;
         assign w_b_i   = bus.in_sub ? ~bus.in_b : bus.in_b;
         assign w_sum_i = '0;
         assign w_ctl_i = '{vld:   bus.in_valid,
                            carry: bus.in_sub | bus.in_cin,
                            a_msb: bus.in_a[WIDTH-1],
                            b_msb: w_b_i[IW-1]};
      end else begin : g_src
         assign w_a_i   = g_stg[k-1].g_hi.r_a;
         assign w_b_i   = g_stg[k-1].g_hi.r_b;
         assign w_sum_i = g_stg[k-1].r_sum;
         assign w_ctl_i = g_stg[k-1].r_ctl;
      end

      for (genvar j = 0; j < NB; j++) begin : g_blk
         logic w_ci, w_co;
         if (j == 0) begin : g_ci
            assign w_ci = w_ctl_i.carry;
         end else begin : g_ci
            assign w_ci = g_blk[j-1].w_co;
         end
         csa_block #(.BLOCK(BLOCK)) u_blk (
            .i_a    (w_a_i[j*BLOCK +: BLOCK]),
            .i_b    (w_b_i[j*BLOCK +: BLOCK]),
            .i_cin  (w_ci),
            .o_sum  (w_s[j*BLOCK +: BLOCK]),
            .o_cout (w_co)
         );
      end

      always_comb begin
         w_sum_n              = w_sum_i;
         w_sum_n[k*SW +: SW]  = w_s;
         w_ctl_n              = w_ctl_i;
         w_ctl_n.carry        = g_blk[NB-1].w_co;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_ctl <= '0;
            r_sum <= '0;
         end else if (w_adv) begin
            r_ctl <= w_ctl_n;
            r_sum <= w_sum_n;
         end
      end

      if (k < STAGES-1) begin : g_hi
         logic [IW-SW-1:0] r_a, r_b;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_a <= '0;
               r_b <= '0;
            end else if (w_adv) begin
               r_a <= w_a_i[IW-1:SW];
               r_b <= w_b_i[IW-1:SW];
            end
         end
      end
   end

   assign w_last_ctl = g_stg[STAGES-1].r_ctl;
   assign w_last_sum = g_stg[STAGES-1].r_sum;

   // Bubble contents are don't-care, so the result is masked by valid.
   assign bus.out_valid = w_last_ctl.vld;
   assign bus.out_sum   = w_last_ctl.vld ? w_last_sum : '0;
   assign bus.out_cout  = w_last_ctl.vld & w_last_ctl.carry;
   assign bus.out_ovf   = w_last_ctl.vld &
                          ovf_of(w_last_ctl.a_msb, w_last_ctl.b_msb, w_last_sum[WIDTH-1]);
endmodule
